// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_responder_pkg;

  typedef logic [31:0] data_t;
  typedef logic        enable_t;

  localparam int unsigned DMEM_SIZE    = 256;
  localparam int unsigned DMEM_LATENCY = 2;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } dmem_state_e;

  // Halves need addr[0] clear, words need addr[1:0] clear.
  function automatic logic dmem_misaligned(mem_size_t size, logic [1:0] addr_lo);
    case (size)
      MEM_H:   return addr_lo[0];
      MEM_W:   return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM stage (master) and the data memory (slave).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic      req_valid_i;
  logic      req_ready_o;
  enable_t   req_write_i;
  data_t     req_addr_i;
  data_t     req_wdata_i;
  mem_size_t req_size_i;
  logic      req_unsigned_i;
  logic      resp_valid_o;
  logic      resp_ready_i;
  data_t     resp_rdata_o;
  logic      resp_err_o;

  modport master (
    output req_valid_i,
    input  req_ready_o,
    output req_write_i,
    output req_addr_i,
    output req_wdata_i,
    output req_size_i,
    output req_unsigned_i,
    input  resp_valid_o,
    output resp_ready_i,
    input  resp_rdata_o,
    input  resp_err_o
  );

  modport slave (
    input  req_valid_i,
    output req_ready_o,
    input  req_write_i,
    input  req_addr_i,
    input  req_wdata_i,
    input  req_size_i,
    input  req_unsigned_i,
    output resp_valid_o,
    input  resp_ready_i,
    output resp_rdata_o,
    output resp_err_o
  );

endinterface

// File: rtl/dmem_responder_align.sv
// Byte-lane steering for stores and lane extract plus sign/zero extension for loads.
module dmem_align
  import dmem_responder_pkg::*;
(
  input  mem_size_t   size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  data_t       wdata_i,
  input  data_t       rword_i,
  output logic [3:0]  wstrb_o,
  output data_t       wword_o,
  output data_t       rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    wstrb_o = 4'b1111;
    wword_o = wdata_i;
    rdata_o = rword_i;
    case (size_i)
      MEM_B: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      end
      MEM_H: begin
        // addr[0] is ignored here; misalignment is flagged upstream when checking is on.
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      end
      default: begin
        wstrb_o = 4'b1111;
        wword_o = wdata_i;
        rdata_o = rword_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder; misalignment trapping is enabled by DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned MEM_SIZE = DMEM_SIZE,
  parameter int unsigned LATENCY  = DMEM_LATENCY
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(MEM_SIZE);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        do_access;
  logic        accept;

  enable_t     write_q;
  data_t       addr_q;
  data_t       wdata_q;
  mem_size_t   size_q;
  logic        unsigned_q;

  data_t       rdata_q, rdata_d;
  logic        err_q, err_d;

  data_t       mem_q [MEM_SIZE];

  enable_t     acc_write;
  data_t       acc_addr;
  data_t       acc_wdata;
  mem_size_t   acc_size;
  logic        acc_unsigned;
  logic [IdxW-1:0] acc_idx;
  data_t       rword;
  logic [3:0]  wstrb;
  data_t       wword;
  data_t       align_rdata;
  logic        misalign;
  logic        mem_we;

  assign accept = bus.req_valid_i && bus.req_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_access = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (LATENCY == 1) begin
            do_access = 1'b1;
            state_d   = StResp;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (bus.resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready_o  = (state_q == StIdle);
    bus.resp_valid_o = (state_q == StResp);
    bus.resp_rdata_o = rdata_q;
    bus.resp_err_o   = err_q;
  end

  // With single-cycle latency the access uses the live request instead of the latched copy.
  always_comb begin
    if (state_q == StIdle) begin
      acc_write    = bus.req_write_i;
      acc_addr     = bus.req_addr_i;
      acc_wdata    = bus.req_wdata_i;
      acc_size     = bus.req_size_i;
      acc_unsigned = bus.req_unsigned_i;
    end else begin
      acc_write    = write_q;
      acc_addr     = addr_q;
      acc_wdata    = wdata_q;
      acc_size     = size_q;
      acc_unsigned = unsigned_q;
    end
  end

  assign acc_idx = acc_addr[IdxW+1:2];
  assign rword   = mem_q[acc_idx];

  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr[31:IdxW+2];

  dmem_align u_align (
    .size_i     (acc_size),
    .addr_lo_i  (acc_addr[1:0]),
    .unsigned_i (acc_unsigned),
    .wdata_i    (acc_wdata),
    .rword_i    (rword),
    .wstrb_o    (wstrb),
    .wword_o    (wword),
    .rdata_o    (align_rdata)
  );

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = dmem_misaligned(acc_size, acc_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign rdata_d = (acc_write || misalign) ? '0 : align_rdata;
  assign err_d   = misalign;
  assign mem_we  = do_access && acc_write && !misalign && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= MEM_B;
      unsigned_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        write_q    <= bus.req_write_i;
        addr_q     <= bus.req_addr_i;
        wdata_q    <= bus.req_wdata_i;
        size_q     <= bus.req_size_i;
        unsigned_q <= bus.req_unsigned_i;
      end
      if (do_access) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[acc_idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one LATENCY=2 and one LATENCY=3 instance.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t_acc;
    int          lat;
  } exp_t;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      sel3 = 1'b0;
  logic      req_valid = 1'b0;
  logic      req_write = 1'b0;
  data_t     req_addr = '0;
  data_t     req_wdata = '0;
  mem_size_t req_size = MEM_W;
  logic      req_unsigned = 1'b0;
  logic      resp_ready = 1'b1;

  logic  ready_o, valid_o, err_o;
  data_t rdata_o;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bus2 ();
  dmem_responder_if bus3 ();

  assign bus2.req_valid_i    = req_valid & ~sel3;
  assign bus3.req_valid_i    = req_valid & sel3;
  assign bus2.req_write_i    = req_write;
  assign bus3.req_write_i    = req_write;
  assign bus2.req_addr_i     = req_addr;
  assign bus3.req_addr_i     = req_addr;
  assign bus2.req_wdata_i    = req_wdata;
  assign bus3.req_wdata_i    = req_wdata;
  assign bus2.req_size_i     = req_size;
  assign bus3.req_size_i     = req_size;
  assign bus2.req_unsigned_i = req_unsigned;
  assign bus3.req_unsigned_i = req_unsigned;
  assign bus2.resp_ready_i   = resp_ready;
  assign bus3.resp_ready_i   = resp_ready;

  assign ready_o = sel3 ? bus3.req_ready_o  : bus2.req_ready_o;
  assign valid_o = sel3 ? bus3.resp_valid_o : bus2.resp_valid_o;
  assign rdata_o = sel3 ? bus3.resp_rdata_o : bus2.resp_rdata_o;
  assign err_o   = sel3 ? bus3.resp_err_o   : bus2.resp_err_o;

  dmem_responder #(.LATENCY(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  dmem_responder #(.LATENCY(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input mem_size_t sz, input logic u, input logic [31:0] er, input logic ee);
    exp_t e;
    int   n;
    req_write = w; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = u;
    req_valid = 1'b1;
    n = 0;
    while (!ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      check("accept_timeout", {31'b0, ready_o}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    // Scramble the request bus; the responder must use only the latched copy.
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_size  = MEM_B;
    e.rdata = er; e.err = ee; e.t_acc = cyc; e.lat = sel3 ? 3 : 2;
    sb.push_back(e);
  endtask

  task automatic recv(input int bp);
    exp_t e;
    int   n;
    resp_ready = (bp == 0);
    n = 0;
    while (!valid_o && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!valid_o) begin
      check("resp_timeout", {31'b0, valid_o}, 32'd1);
      resp_ready = 1'b1;
      return;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("latency", 32'(cyc - e.t_acc + 1), 32'(e.lat));
    check("rdata", rdata_o, e.rdata);
    check("err", {31'b0, err_o}, {31'b0, e.err});
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", {31'b0, valid_o}, 32'd1);
      check("bp_rdata", rdata_o, e.rdata);
      check("bp_req_ready", {31'b0, ready_o}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("resp_drop", {31'b0, valid_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_hs;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel3 = 1'(s);
      #1;
      check("rst_req_ready", {31'b0, ready_o}, 32'd1);
      check("rst_resp_valid", {31'b0, valid_o}, 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
      check("rst_err", {31'b0, err_o}, 32'd0);
    end
    sel3 = 1'b0;
    @(negedge clk);

    // Word and sub-word accesses
    send(1'b1, 32'h10, 32'hDEADBEEF, MEM_W, 1'b0, 32'h0, 1'b0);          recv(0);
    send(1'b0, 32'h10, 32'h0, MEM_W, 1'b0, 32'hDEADBEEF, 1'b0);          recv(0);
    send(1'b0, 32'h13, 32'h0, MEM_B, 1'b0, 32'hFFFFFFDE, 1'b0);          recv(0);
    send(1'b0, 32'h13, 32'h0, MEM_B, 1'b1, 32'h000000DE, 1'b0);          recv(0);
    send(1'b0, 32'h10, 32'h0, MEM_H, 1'b0, 32'hFFFFBEEF, 1'b0);          recv(0);
    send(1'b0, 32'h12, 32'h0, MEM_H, 1'b1, 32'h0000DEAD, 1'b0);          recv(0);
    send(1'b1, 32'h11, 32'hFFFFFF55, MEM_B, 1'b0, 32'h0, 1'b0);          recv(0);
    send(1'b0, 32'h10, 32'h0, MEM_W, 1'b1, 32'hDEAD55EF, 1'b0);          recv(0);
    send(1'b1, 32'h12, 32'h12347A5A, MEM_H, 1'b0, 32'h0, 1'b0);          recv(0);
    send(1'b0, 32'h12, 32'h0, MEM_H, 1'b0, 32'h00007A5A, 1'b0);          recv(0);
    send(1'b0, 32'h10, 32'h0, MEM_W, 1'b0, 32'h7A5A55EF, 1'b0);          recv(0);

    // Backpressure with a competing request held on the bus
    send(1'b0, 32'h10, 32'h0, MEM_W, 1'b0, 32'h7A5A55EF, 1'b0);
    req_write = 1'b0; req_addr = 32'h11; req_size = MEM_B; req_unsigned = 1'b1;
    req_valid = 1'b1;
    recv(5);
    t_hs = cyc;
    check("ready_after_hs", {31'b0, ready_o}, 32'd1);
    send(1'b0, 32'h11, 32'h0, MEM_B, 1'b1, 32'h00000055, 1'b0);
    check("accept_after_hs", 32'(sb[0].t_acc), 32'(t_hs + 1));
    recv(0);

    // Upper address bits wrap
    send(1'b1, 32'(4 * DMEM_SIZE + 8), 32'h0BADF00D, MEM_W, 1'b0, 32'h0, 1'b0); recv(0);
    send(1'b0, 32'h8, 32'h0, MEM_W, 1'b0, 32'h0BADF00D, 1'b0);                  recv(0);

    // Misalignment
    send(1'b1, 32'h20, 32'hAABBCCDD, MEM_W, 1'b0, 32'h0, 1'b0);                 recv(0);
`ifdef DMEM_MISALIGN_CHECK_EN
    send(1'b0, 32'h22, 32'h0, MEM_W, 1'b0, 32'h0, 1'b1);                        recv(0);
    send(1'b1, 32'h22, 32'h11111111, MEM_W, 1'b0, 32'h0, 1'b1);                 recv(0);
    send(1'b0, 32'h21, 32'h0, MEM_H, 1'b0, 32'h0, 1'b1);                        recv(0);
    send(1'b0, 32'h20, 32'h0, MEM_W, 1'b0, 32'hAABBCCDD, 1'b0);                 recv(0);
`else
    send(1'b0, 32'h22, 32'h0, MEM_W, 1'b0, 32'hAABBCCDD, 1'b0);                 recv(0);
    send(1'b1, 32'h22, 32'h11111111, MEM_W, 1'b0, 32'h0, 1'b0);                 recv(0);
    send(1'b0, 32'h21, 32'h0, MEM_H, 1'b0, 32'h00001111, 1'b0);                 recv(0);
    send(1'b0, 32'h20, 32'h0, MEM_W, 1'b0, 32'h11111111, 1'b0);                 recv(0);
`endif

    // LATENCY=3 instance: reset during the first BUSY cycle of a store
    sel3 = 1'b1;
    @(negedge clk);
    send(1'b1, 32'h20, 32'hCAFEF00D, MEM_W, 1'b0, 32'h0, 1'b0);                 recv(0);
    send(1'b1, 32'h20, 32'h12345678, MEM_W, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("midrst_req_ready", {31'b0, ready_o}, 32'd1);
    check("midrst_resp_valid", {31'b0, valid_o}, 32'd0);
    check("midrst_rdata", rdata_o, 32'd0);
    repeat (4) @(negedge clk);
    check("midrst_no_resp", {31'b0, valid_o}, 32'd0);
    send(1'b0, 32'h20, 32'h0, MEM_W, 1'b0, 32'hCAFEF00D, 1'b0);                 recv(0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
